// File: rtl/segre_store_buffer.sv
// segre_store_buffer: FIFO of committed stores between TL and MEM with same-cycle load lookup.
// Optional macro SB_FORWARDING_EN enables store-to-load forwarding; without it any overlap stalls.
package segre_store_buffer_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
endpackage

module segre_store_buffer
  import segre_store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH  = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 push_i,
  input  logic [ADDR_SIZE-1:0] push_addr_i,
  input  logic [WORD_SIZE-1:0] push_data_i,
  input  memop_data_type_e     push_type_i,
  input  logic                 ld_i,
  input  logic [ADDR_SIZE-1:0] ld_addr_i,
  input  memop_data_type_e     ld_type_i,
  input  logic                 drain_en_i,
  output logic                 hit_o,
  output logic [WORD_SIZE-1:0] hit_data_o,
  output logic                 conflict_o,
  output logic                 data_valid_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [WORD_SIZE-1:0] data_o,
  output memop_data_type_e     type_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AW1   = ADDR_SIZE + 1;

  logic [ADDR_SIZE-1:0] addr_q [SB_DEPTH];
  logic [WORD_SIZE-1:0] data_q [SB_DEPTH];
  memop_data_type_e     type_q [SB_DEPTH];
  logic [SB_DEPTH-1:0]  valid_q, valid_n;
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  logic                 pop, push_ok;

  function automatic logic [2:0] size_bytes(input memop_data_type_e t);
    case (t)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Ranges are widened by one bit so addr + size never wraps at the top of memory.
  function automatic logic overlaps(input logic [ADDR_SIZE-1:0] a, input memop_data_type_e at,
                                    input logic [ADDR_SIZE-1:0] b, input memop_data_type_e bt);
    logic [AW1-1:0] a0, a1, b0, b1;
    a0 = {1'b0, a};
    b0 = {1'b0, b};
    a1 = a0 + AW1'(size_bytes(at));
    b1 = b0 + AW1'(size_bytes(bt));
    return (a0 < b1) && (b0 < a1);
  endfunction

  assign full_o       = (count_q == CNT_W'(SB_DEPTH));
  assign empty_o      = (count_q == '0);
  assign data_valid_o = !empty_o && drain_en_i;
  assign pop          = data_valid_o;
  assign push_ok      = push_i && (!full_o || pop);
  assign addr_o       = addr_q[head_q];
  assign data_o       = data_q[head_q];
  assign type_o       = type_q[head_q];

  always_comb begin
    valid_n = valid_q;
    if (pop)     valid_n[head_q] = 1'b0;
    if (push_ok) valid_n[tail_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        type_q[i] <= BYTE;
      end
    end else begin
      valid_q <= valid_n;
      if (push_ok) begin
        addr_q[tail_q] <= push_addr_i;
        data_q[tail_q] <= push_data_i;
        type_q[tail_q] <= push_type_i;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (pop) head_q <= head_q + PTR_W'(1);
      if (push_ok && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push_ok && pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Scan oldest to youngest so the last overlapping entry seen is the youngest.
  logic             found;
  logic [PTR_W-1:0] idx;
`ifdef SB_FORWARDING_EN
  logic [ADDR_SIZE-1:0] y_addr;
  logic [WORD_SIZE-1:0] y_data;
  memop_data_type_e     y_type;
  logic                 match;
`endif

  always_comb begin
    found = 1'b0;
    idx   = '0;
`ifdef SB_FORWARDING_EN
    y_addr = '0;
    y_data = '0;
    y_type = BYTE;
`endif
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && overlaps(addr_q[idx], type_q[idx], ld_addr_i, ld_type_i)) begin
        found = 1'b1;
`ifdef SB_FORWARDING_EN
        y_addr = addr_q[idx];
        y_data = data_q[idx];
        y_type = type_q[idx];
`endif
      end
    end
  end

`ifdef SB_FORWARDING_EN
  always_comb begin
    match      = (y_addr == ld_addr_i) && (size_bytes(y_type) >= size_bytes(ld_type_i));
    hit_o      = ld_i && found && match;
    conflict_o = ld_i && found && !match;
    hit_data_o = '0;
    if (hit_o) begin
      case (ld_type_i)
        BYTE:    hit_data_o = y_data & WORD_SIZE'(8'hFF);
        HALF:    hit_data_o = y_data & WORD_SIZE'(16'hFFFF);
        default: hit_data_o = y_data;
      endcase
    end
  end
`else
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    conflict_o = ld_i && found;
  end
`endif

endmodule

// File: doc/segre_store_buffer.md
Name: segre_store_buffer

Overview:
- FIFO store buffer between the TL stage and the MEM stage.
- Accepts committed stores from TL and forwards store data to younger loads in the same cycle.
- Drains the oldest entry into the data cache whenever the cache write port is free.
- Supplies the MEM stage with the signals it consumes: hit and forwarded data for loads, and valid/address/data for drains.

Parameters:
SB_DEPTH, 4, number of entries; power of two, minimum 2
WORD_SIZE, 32, store data width
ADDR_SIZE, 32, address width

Ports:
clk_i  in  1  clock
rsn_i  in  1  synchronous active-low reset
push_i  in  1  store enters the buffer (TL memop_wr)
push_addr_i  in  ADDR_SIZE  store byte address
push_data_i  in  WORD_SIZE  store data, right-aligned
push_type_i  in  memop_data_type_e  BYTE/HALF/WORD
ld_i  in  1  load in TL/MEM (memop_rd)
ld_addr_i  in  ADDR_SIZE  load byte address
ld_type_i  in  memop_data_type_e  load size
drain_en_i  in  1  cache write port free this cycle (no load, no MMU fill)
hit_o  out  1  load fully covered by a buffered store
hit_data_o  out  WORD_SIZE  forwarded data, right-aligned, unextended
conflict_o  out  1  load partially overlaps a buffered store; stall load
data_valid_o  out  1  drain write presented to the cache
addr_o  out  ADDR_SIZE  drain address
data_o  out  WORD_SIZE  drain data
type_o  out  memop_data_type_e  drain size
full_o  out  1  count == SB_DEPTH
empty_o  out  1  count == 0

Behaviour:
- State: SB_DEPTH entries {addr, data, type}; head (oldest) and tail pointers, log2(SB_DEPTH) bits, wrapping modulo SB_DEPTH; count, 0..SB_DEPTH.
- Reset (rsn_i low at posedge): head = tail = count = 0, all entry valid bits cleared. Outputs after reset: empty_o = 1, full_o = 0, data_valid_o = 0, hit_o = 0, conflict_o = 0, hit_data_o/addr_o/data_o = 0. Reset mid-drain discards all entries; no write is issued.
- Push: when push_i && (!full_o || pop this cycle), the entry is written at tail and tail increments at the posedge.
  - A push while full with no pop is dropped and count is unchanged; upstream must stall on full_o.
- Drain (pop): data_valid_o = !empty_o && drain_en_i, combinational. addr_o/data_o/type_o always show the head entry.
  - When data_valid_o = 1, the cache writes that cycle and head increments at the posedge.
- Simultaneous push and pop: count unchanged, both pointers advance. When empty, a push is never drained in the same cycle; the earliest drain is the next cycle.
- Lookup (combinational, zero latency), when ld_i = 1:
  - Overlap: an entry overlaps the load if their byte ranges [addr, addr + size) intersect.
  - hit_o = 1 only when the youngest overlapping entry has addr == ld_addr_i and size >= load size. hit_data_o is that entry's data masked to the load size; the upper bits are 0.
  - conflict_o = 1 when the youngest overlapping entry fails the hit rule. hit_o and conflict_o are never both 1.
  - With ld_i = 0, or no overlap: hit_o = conflict_o = 0.
  - An entry pushed in the current cycle is not visible to a lookup until the next cycle.
  - An entry popped in the current cycle is still visible this cycle.
- Size encoding for comparison: BYTE = 1, HALF = 2, WORD = 4 bytes.

Optional Feature:
SB_FORWARDING_EN
- Defined: lookup and forwarding behave as above.
- Undefined: hit_o is tied to 0 and hit_data_o to 0. conflict_o = 1 for any overlap, so every load aliasing a buffered store stalls until that store drains. Lookup area is reduced to overlap detection only.

Test Plan:
- Reset with 3 entries buffered -> next cycle empty_o = 1, count = 0, data_valid_o = 0 even with drain_en_i = 1.
- Push WORD 0x1000/0xDEADBEEF, then next cycle ld WORD 0x1000 -> hit_o = 1, hit_data_o = 0xDEADBEEF; ld BYTE 0x1000 -> hit_data_o = 0x000000EF.
- Push BYTE 0x1002/0xAB, then ld WORD 0x1000 -> conflict_o = 1, hit_o = 0. After drain -> conflict_o = 0.
- Push WORD 0x2000 = 0x11111111, then WORD 0x2000 = 0x22222222, then ld WORD 0x2000 -> hit_data_o = 0x22222222 (youngest wins).
- Push 4 stores with drain_en_i = 0 -> full_o = 1. A 5th push with drain_en_i = 0 is dropped. A 5th push with drain_en_i = 1 is accepted and the oldest drains; count stays 4.
- Drain 6 pushes through a depth-4 buffer -> addresses appear on addr_o in push order across pointer wrap, one per cycle with drain_en_i held at 1.
